// File: rtl/helper_axis_pattern_generator_if.sv
// AXI-Stream beat bus between the pattern generator (master) and the block under test (slave).
interface helper_axis_pattern_generator_if #(
   parameter int unsigned DATA_WIDTH = 10
);
   logic                  output_valid;
   logic [DATA_WIDTH-1:0] output_data;
   logic                  output_last;
   logic                  output_ready;

   modport master (
      output output_valid,
      output output_data,
      output output_last,
      input  output_ready
   );

   modport slave (
      input  output_valid,
      input  output_data,
      input  output_last,
      output output_ready
   );
endinterface

// File: rtl/helper_axis_pattern_generator.sv
// AXI-Stream test-data source: counter or Galois-LFSR beats with packet framing,
// valid duty-cycle throttling and an optional finite run length.
module helper_axis_pattern_generator #(
   parameter int unsigned     DATA_WIDTH  = 10,
   parameter int unsigned     MODE        = 0,
   parameter longint unsigned START_AT    = 0,
   parameter longint unsigned STEP        = 1,
   parameter longint unsigned END_AT      = (DATA_WIDTH >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF :
                                            ((64'd1 << DATA_WIDTH) - 64'd1),
   parameter logic [31:0]     SEED        = 32'd1,
   parameter int unsigned     PACKET_LEN  = 16,
   parameter int unsigned     VALID_ON    = 1,
   parameter int unsigned     VALID_OFF   = 0,
   parameter int unsigned     TOTAL_BEATS = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              enable,
   helper_axis_pattern_generator_if.master   axis,
   output logic                              done,
   output logic [31:0]                       beat_count
);

   localparam logic [1:0] StRun  = 2'd0;
   localparam logic [1:0] StGap  = 2'd1;
   localparam logic [1:0] StDone = 2'd2;

   localparam logic [31:0]           SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
   localparam logic [DATA_WIDTH-1:0] START_D  = DATA_WIDTH'(START_AT);
   localparam logic [DATA_WIDTH:0]   STEP_W   = (DATA_WIDTH + 1)'(STEP);
   localparam logic [DATA_WIDTH:0]   END_W    = (DATA_WIDTH + 1)'(END_AT);
   localparam logic [31:0]           PKT_LAST = 32'(PACKET_LEN - 1);
   localparam logic [31:0]           BURST_N  = 32'(VALID_ON);
   localparam logic [31:0]           GAP_N    = 32'(VALID_OFF);
   localparam logic [32:0]           TOTAL_W  = {1'b0, 32'(TOTAL_BEATS)};
   localparam logic                  LAST_RST = (PACKET_LEN == 1) || (TOTAL_BEATS == 1);

   logic [1:0]            state_q, state_d;
   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  last_q, last_d;
   logic                  done_q, done_d;
   logic [31:0]           beat_q, beat_d;
   logic [31:0]           pkt_q, pkt_d;
   logic [31:0]           burst_q, burst_d;
   logic [31:0]           gap_q, gap_d;
   logic [31:0]           lfsr_q, lfsr_d;

   logic [DATA_WIDTH-1:0] data_next;
   logic [DATA_WIDTH-1:0] data_rst;
   logic [31:0]           lfsr_adv;

   generate
      if (MODE == 1) begin : g_lfsr
         assign lfsr_adv  = (lfsr_q >> 1) ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
         assign data_next = lfsr_adv[DATA_WIDTH-1:0];
         assign data_rst  = SEED_EFF[DATA_WIDTH-1:0];
      end else begin : g_cnt
         // One extra bit so data+STEP cannot wrap before the END_AT compare.
         logic [DATA_WIDTH:0] sum;
         assign sum       = {1'b0, data_q} + STEP_W;
         assign data_next = (sum > END_W) ? START_D : sum[DATA_WIDTH-1:0];
         assign data_rst  = START_D;
         assign lfsr_adv  = lfsr_q;
      end
   endgenerate

   logic        xfer;
   logic [31:0] beat_inc;
   logic [31:0] pkt_inc;
   logic        final_beat;
   logic        next_final;

   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      data_d     = data_q;
      last_d     = last_q;
      done_d     = done_q;
      beat_d     = beat_q;
      pkt_d      = pkt_q;
      burst_d    = burst_q;
      gap_d      = gap_q;
      lfsr_d     = lfsr_q;
      xfer       = valid_q & axis.output_ready;
      beat_inc   = (beat_q == 32'hFFFF_FFFF) ? beat_q : beat_q + 32'd1;
      pkt_inc    = (pkt_q == PKT_LAST) ? 32'd0 : pkt_q + 32'd1;
      final_beat = (TOTAL_BEATS != 0) && (({1'b0, beat_q} + 33'd1) == TOTAL_W);
      next_final = (TOTAL_BEATS != 0) && (({1'b0, beat_inc} + 33'd1) == TOTAL_W);

      unique case (state_q)
         StRun: begin
            if (xfer) begin
               beat_d = beat_inc;
               pkt_d  = pkt_inc;
               data_d = data_next;
               lfsr_d = lfsr_adv;
               last_d = (pkt_inc == PKT_LAST) || next_final;
               if (final_beat) begin
                  state_d = StDone;
                  done_d  = 1'b1;
                  valid_d = 1'b0;
                  burst_d = 32'd0;
               end else if ((VALID_OFF != 0) && (burst_q + 32'd1 == BURST_N)) begin
                  state_d = StGap;
                  gap_d   = GAP_N;
                  burst_d = 32'd0;
                  valid_d = 1'b0;
               end else begin
                  burst_d = burst_q + 32'd1;
                  valid_d = enable;
               end
            end else if (!valid_q && enable) begin
               valid_d = 1'b1;
            end
         end
         StGap: begin
            // Leave on the last gap cycle so valid is back exactly VALID_OFF cycles later.
            if (gap_q <= 32'd1) begin
               state_d = StRun;
               valid_d = enable;
               gap_d   = 32'd0;
            end else begin
               gap_d = gap_q - 32'd1;
            end
         end
         StDone: begin
            valid_d = 1'b0;
         end
         default: begin
            state_d = StRun;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StRun;
         valid_q <= 1'b0;
         data_q  <= data_rst;
         last_q  <= LAST_RST;
         done_q  <= 1'b0;
         beat_q  <= 32'd0;
         pkt_q   <= 32'd0;
         burst_q <= 32'd0;
         gap_q   <= 32'd0;
         lfsr_q  <= SEED_EFF;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         last_q  <= last_d;
         done_q  <= done_d;
         beat_q  <= beat_d;
         pkt_q   <= pkt_d;
         burst_q <= burst_d;
         gap_q   <= gap_d;
         lfsr_q  <= lfsr_d;
      end
   end

   assign axis.output_valid = valid_q;
   assign axis.output_data  = data_q;
   assign axis.output_last  = last_q;
   assign done              = done_q;
   assign beat_count        = beat_q;

endmodule
